// File: rtl/lvdc_buffer_register.sv
// lvdc_buffer_register: parametrised multi-channel LVDC memory buffer register.
// Each channel OR-accumulates a syllable from its interleaved memory modules,
// the transfer register and the parity generator, then locks the word at
// end-of-read. Bit WIDTH of each stored word is the parity bit.
// Optional feature macro: LVDC_BR_PARITY_CHECK_EN enables the odd-parity
// checker and the sticky PERR flags; without it PERR is tied to zero.
module lvdc_buffer_register #(
  parameter int WIDTH = 13,
  parameter int NCH   = 2,
  parameter int NMOD  = 8
) (
  input  logic                          SIM_CLK,
  input  logic                          SIM_RST,
  input  logic                          V1,
  input  logic [NCH-1:0]                CBRVN,
  input  logic [NCH-1:0]                SBRXV,
  input  logic [NCH*WIDTH-1:0]          TRV,
  input  logic [NCH-1:0]                PARV,
  input  logic [NMOD*(WIDTH+1)-1:0]     MSA,
  input  logic [NCH-1:0]                RDEND,
  output logic [NCH*(WIDTH+1)-1:0]      BR,
  output logic [NCH*(WIDTH+1)-1:0]      BRN,
  output logic [NCH-1:0]                HELD,
  output logic [NCH-1:0]                PERR
);

  localparam int W = WIDTH + 1;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_HELD    = 2'd2
  } state_e;

  state_e       state_q [NCH];
  state_e       state_d [NCH];
  logic [W-1:0] br_q    [NCH];
  logic [W-1:0] br_d    [NCH];
  logic [W-1:0] set_s   [NCH];
  logic [W-1:0] merged_s[NCH];
  logic [NCH-1:0] clr_s;
  logic [NCH-1:0] eor_s;

  // Gather every set source for each channel: its interleaved modules, the
  // gated transfer register and the parity generator bit.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      set_s[c] = '0;
      for (int m = 0; m < NMOD; m++) begin
        if ((m % NCH) == c) begin
          set_s[c] = set_s[c] | MSA[m*W +: W];
        end
      end
      if (SBRXV[c]) begin
        set_s[c] = set_s[c] | {1'b0, TRV[c*WIDTH +: WIDTH]};
      end
      if (PARV[c]) begin
        set_s[c][WIDTH] = 1'b1;
      end
    end
  end

  // Decode qualified clear and end-of-read events; clear wins over
  // end-of-read, and a held channel ignores end-of-read entirely.
  always_comb begin
    clr_s = '0;
    eor_s = '0;
    for (int c = 0; c < NCH; c++) begin
      clr_s[c] = V1 & ~CBRVN[c];
      eor_s[c] = V1 & CBRVN[c] & RDEND[c] & (state_q[c] != ST_HELD);
    end
  end

  // Next-state and next-contents per channel: clear loads the current set
  // sources, otherwise non-held channels keep OR-accumulating.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      state_d[c]  = state_q[c];
      br_d[c]     = br_q[c];
      merged_s[c] = br_q[c] | set_s[c];
      if (clr_s[c]) begin
        br_d[c]    = set_s[c];
        state_d[c] = (set_s[c] != '0) ? ST_LOADING : ST_EMPTY;
      end else if (V1) begin
        unique case (state_q[c])
          ST_HELD: begin
            state_d[c] = ST_HELD;
          end
          default: begin
            br_d[c] = merged_s[c];
            if (eor_s[c]) begin
              state_d[c] = ST_HELD;
            end else if (merged_s[c] != '0) begin
              state_d[c] = ST_LOADING;
            end
          end
        endcase
      end
    end
  end

  // Channel state and contents registers; reset drops any partial word.
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      for (int c = 0; c < NCH; c++) begin
        br_q[c]    <= '0;
        state_q[c] <= ST_EMPTY;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        br_q[c]    <= br_d[c];
        state_q[c] <= state_d[c];
      end
    end
  end

`ifdef LVDC_BR_PARITY_CHECK_EN
  logic [NCH-1:0] perr_q;
  logic [NCH-1:0] perr_d;

  // Sticky odd-parity check, evaluated on the word being locked at
  // end-of-read; clear drops the flag.
  always_comb begin
    perr_d = perr_q;
    for (int c = 0; c < NCH; c++) begin
      if (clr_s[c]) begin
        perr_d[c] = 1'b0;
      end else if (eor_s[c]) begin
        perr_d[c] = perr_q[c] | ~(^merged_s[c]);
      end
    end
  end

  // Parity error flag register.
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      perr_q <= '0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign PERR = perr_q;
`else
  assign PERR = '0;
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign BR[g*W +: W] = br_q[g];
    assign HELD[g]      = (state_q[g] == ST_HELD);
  end

  assign BRN = ~BR;

endmodule

// File: tb/tb_lvdc_buffer_register.sv
// tb_lvdc_buffer_register: directed self-checking bench for the default
// two-channel, 13-bit, eight-module buffer register.
module tb_lvdc_buffer_register;

  localparam int WIDTH = 13;
  localparam int NCH   = 2;
  localparam int NMOD  = 8;
  localparam int W     = WIDTH + 1;

  logic                    SIM_CLK;
  logic                    SIM_RST;
  logic                    V1;
  logic [NCH-1:0]          CBRVN;
  logic [NCH-1:0]          SBRXV;
  logic [NCH*WIDTH-1:0]    TRV;
  logic [NCH-1:0]          PARV;
  logic [NMOD*W-1:0]       MSA;
  logic [NCH-1:0]          RDEND;
  logic [NCH*W-1:0]        BR;
  logic [NCH*W-1:0]        BRN;
  logic [NCH-1:0]          HELD;
  logic [NCH-1:0]          PERR;

  int testsRun    = 0;
  int testsFailed = 0;
  logic expPerrOdd;

  lvdc_buffer_register #(
    .WIDTH(WIDTH),
    .NCH  (NCH),
    .NMOD (NMOD)
  ) dut (
    .SIM_CLK(SIM_CLK),
    .SIM_RST(SIM_RST),
    .V1     (V1),
    .CBRVN  (CBRVN),
    .SBRXV  (SBRXV),
    .TRV    (TRV),
    .PARV   (PARV),
    .MSA    (MSA),
    .RDEND  (RDEND),
    .BR     (BR),
    .BRN    (BRN),
    .HELD   (HELD),
    .PERR   (PERR)
  );

  initial begin
    SIM_CLK = 1'b0;
    forever #5 SIM_CLK = ~SIM_CLK;
  end

  function automatic logic [W-1:0] brOf(input int c);
    return BR[c*W +: W];
  endfunction

  function automatic logic [W-1:0] brnOf(input int c);
    return BRN[c*W +: W];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic idleInputs();
    V1    = 1'b1;
    CBRVN = '1;
    SBRXV = '0;
    TRV   = '0;
    PARV  = '0;
    MSA   = '0;
    RDEND = '0;
  endtask

  // One rising edge with the currently driven inputs, then back to idle.
  task automatic applyStimulus();
    @(posedge SIM_CLK);
    #1;
    idleInputs();
  endtask

  initial begin
`ifdef LVDC_BR_PARITY_CHECK_EN
    expPerrOdd = 1'b1;
`else
    expPerrOdd = 1'b0;
`endif
    idleInputs();
    SIM_RST = 1'b0;
    repeat (3) @(posedge SIM_CLK);
    #1;
    checkOutput("rst_br",   32'(BR),   32'h0);
    checkOutput("rst_brn",  32'(BRN),  32'h0FFF_FFFF);
    checkOutput("rst_held", 32'(HELD), 32'h0);
    checkOutput("rst_perr", 32'(PERR), 32'h0);
    SIM_RST = 1'b1;
    applyStimulus();

    // Interleave: modules 2 and 4 feed channel 0, module 3 feeds channel 1.
    MSA[2*W +: W] = 14'h0005;
    MSA[3*W +: W] = 14'h0100;
    applyStimulus();
    checkOutput("il1_br0", 32'(brOf(0)), 32'h0005);
    MSA[4*W +: W] = 14'h0030;
    applyStimulus();
    checkOutput("il2_br0",  32'(brOf(0)), 32'h0035);
    checkOutput("il2_br1",  32'(brOf(1)), 32'h0100);
    checkOutput("il2_brn0", 32'(brnOf(0)), 32'h3FCA);
    checkOutput("il2_held", 32'(HELD), 32'h0);

    // Asynchronous reset mid-load.
    SIM_RST = 1'b0;
    #1;
    checkOutput("arst_br",   32'(BR),   32'h0);
    checkOutput("arst_brn0", 32'(brnOf(0)), 32'h3FFF);
    checkOutput("arst_brn1", 32'(brnOf(1)), 32'h3FFF);
    checkOutput("arst_held", 32'(HELD), 32'h0);
    checkOutput("arst_perr", 32'(PERR), 32'h0);
    @(posedge SIM_CLK);
    #1;
    SIM_RST = 1'b1;

    // Reload and lock channel 0 with a good parity bit.
    MSA[2*W +: W] = 14'h0035;
    MSA[3*W +: W] = 14'h0100;
    applyStimulus();
    checkOutput("rl_br0", 32'(brOf(0)), 32'h0035);
    RDEND[0] = 1'b1;
    PARV[0]  = 1'b1;
    applyStimulus();
    checkOutput("par_br0",  32'(brOf(0)), 32'h2035);
    checkOutput("par_held", 32'(HELD), 32'h1);
    checkOutput("par_perr", 32'(PERR), 32'h0);
    checkOutput("par_br1",  32'(brOf(1)), 32'h0100);

    // Lockout: held channel ignores sets and end-of-read.
    MSA[0*W +: W] = 14'h1FFF;
    SBRXV[0] = 1'b1;
    TRV[0 +: WIDTH] = 13'h0AAA;
    RDEND[0] = 1'b1;
    applyStimulus();
    checkOutput("lock_br0",  32'(brOf(0)), 32'h2035);
    checkOutput("lock_held", 32'(HELD), 32'h1);
    CBRVN[0] = 1'b0;
    applyStimulus();
    checkOutput("lclr_br0",  32'(brOf(0)), 32'h0);
    checkOutput("lclr_held", 32'(HELD), 32'h0);
    checkOutput("lclr_perr", 32'(PERR), 32'h0);

    // Even word locked without parity bit.
    MSA[2*W +: W] = 14'h0035;
    applyStimulus();
    RDEND[0] = 1'b1;
    applyStimulus();
    checkOutput("bad_br0",  32'(brOf(0)), 32'h0035);
    checkOutput("bad_held", 32'(HELD), 32'h1);
    checkOutput("bad_perr", 32'(PERR), 32'(expPerrOdd));
    applyStimulus();
    checkOutput("bad_stky", 32'(PERR), 32'(expPerrOdd));

    // Clear with simultaneous set and end-of-read.
    CBRVN[0] = 1'b0;
    SBRXV[0] = 1'b1;
    TRV[0 +: WIDTH] = 13'h0042;
    RDEND[0] = 1'b1;
    applyStimulus();
    checkOutput("cse_br0",  32'(brOf(0)), 32'h0042);
    checkOutput("cse_held", 32'(HELD), 32'h0);
    checkOutput("cse_perr", 32'(PERR), 32'h0);
    RDEND[0] = 1'b1;
    PARV[0]  = 1'b1;
    applyStimulus();
    checkOutput("cse_lk0",  32'(brOf(0)), 32'h2042);
    checkOutput("cse_hld2", 32'(HELD), 32'h1);
    checkOutput("cse_prr2", 32'(PERR), 32'h0);

    // V1 gating: everything active but frozen for three cycles.
    for (int i = 0; i < 3; i++) begin
      V1    = 1'b0;
      CBRVN = '0;
      SBRXV = '1;
      TRV   = {13'h0200, 13'h0011};
      MSA[3*W +: W] = 14'h0007;
      RDEND = '1;
      applyStimulus();
      checkOutput($sformatf("v1g%0d_br", i),   32'(BR),   {4'h0, 14'h0100, 14'h2042});
      checkOutput($sformatf("v1g%0d_held", i), 32'(HELD), 32'h1);
    end
    CBRVN = '0;
    SBRXV = '1;
    TRV   = {13'h0200, 13'h0011};
    MSA[3*W +: W] = 14'h0007;
    RDEND = '1;
    applyStimulus();
    checkOutput("v1on_br0",  32'(brOf(0)), 32'h0011);
    checkOutput("v1on_br1",  32'(brOf(1)), 32'h0207);
    checkOutput("v1on_held", 32'(HELD), 32'h0);
    checkOutput("v1on_perr", 32'(PERR), 32'h0);

    // Channel 1 locks independently while channel 0 keeps loading.
    RDEND[1] = 1'b1;
    MSA[0*W +: W] = 14'h0100;
    applyStimulus();
    checkOutput("ind_br0",  32'(brOf(0)), 32'h0111);
    checkOutput("ind_br1",  32'(brOf(1)), 32'h0207);
    checkOutput("ind_held", 32'(HELD), 32'h2);
    checkOutput("ind_perr", 32'(PERR), 32'(expPerrOdd) << 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
